// File: rtl/spi_slave_responder_if.sv
// Bus bundle between the SPI responder and its host/master side.
// The slave modport is the responder's view; master is the driver's view.
interface spi_slave_responder_if #(
  parameter int WIDTH = 12
);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_responder.sv
// Mode-0, LSB-first SPI slave that oversamples sclk/cs/mosi in the clk domain,
// receives one WIDTH-bit word per frame and answers with a host-loaded word.
module spi_slave_responder #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_responder_if.slave bus
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [WIDTH-1:0] tx_shift, rx_shift, rx_next, rx_word, hold_data;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic [SW-1:0]    settle_cnt;
  logic             settle_done;
  logic             busy_q, rx_valid_q, underrun_q, frame_err_q;

  logic frame_start, rx_step, tx_step, word_done, abort, excess, end_frame;
  logic capture, consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // After reset the synchronizer still holds its reset value of cs=1, so the
  // real pin level is only trusted once the whole chain has been refilled.
  assign settle_done = (settle_cnt == SW'(SETTLE));

  assign rx_next = {mosi_s, rx_shift[WIDTH-1:1]};
  assign capture = bus.tx_valid & ~hold_full;
  assign consume = frame_start & hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    rx_step     = 1'b0;
    tx_step     = 1'b0;
    word_done   = 1'b0;
    abort       = 1'b0;
    excess      = 1'b0;
    end_frame   = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (settle_done && cs_s) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // A cs rise wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          rx_step = 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            word_done  = 1'b1;
            state_next = WAIT_CS;
          end
        end else if (sclk_fall) begin
          tx_step = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          excess = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_word     <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      settle_cnt  <= '0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (state == WAIT_IDLE && !settle_done) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      // A word captured in the frame-start cycle is held for the next frame.
      if (capture) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      if (frame_start) begin
        busy_q  <= 1'b1;
        bit_cnt <= '0;
        if (hold_full) begin
          tx_shift <= hold_data;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end

      if (rx_step) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + CW'(1);
      end

      if (word_done) begin
        rx_word    <= rx_next;
        rx_valid_q <= 1'b1;
      end

      if (tx_step) begin
        tx_shift <= {1'b0, tx_shift[WIDTH-1:1]};
      end

      if (abort || excess) begin
        frame_err_q <= 1'b1;
      end

      if (abort || end_frame) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.miso        = busy_q & tx_shift[0];
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_word;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench: an SPI master drives directed and random frames while a
// frame-level model predicts miso bits, received words and strobe counts.
module tb_spi_slave_responder;

  localparam int W    = 12;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_responder_if #(.WIDTH(W)) bus ();

  spi_slave_responder #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         rxv_cnt  = 0;
  int         ferr_cnt = 0;
  int         und_cnt  = 0;
  logic [W-1:0] last_rx = '0;

  // Reference model state: pending host words and the last good received word.
  logic [W-1:0] hold_q[$];
  logic [W-1:0] model_rx = '0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt <= rxv_cnt + 1;
      last_rx <= bus.rx_data;
    end
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (bus.tx_underrun === 1'b1) und_cnt <= und_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic loadTx(input logic [W-1:0] d);
    int n;
    n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput("tx_ready_wait", 32'(n < 100), 32'd1);
    tick(1);
    bus.tx_valid = 1'b0;
    checkOutput("tx_ready_drop", 32'(bus.tx_ready), 32'd0);
    hold_q.push_back(d);
  endtask

  task automatic sendBit(input logic b, output logic m);
    bus.mosi = b;
    tick(HALF);
    m = bus.miso;
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] word, input int nbits,
                               input bit mid_load, input logic [W-1:0] mid_word);
    logic [W-1:0] exp_tx, got_miso, mask;
    logic         exp_und, m, b;
    int           rxv0, ferr0, und0, exp_ferr;
    if (hold_q.size() > 0) begin
      exp_tx  = hold_q.pop_front();
      exp_und = 1'b0;
    end else begin
      exp_tx  = '0;
      exp_und = 1'b1;
    end
    rxv0     = rxv_cnt;
    ferr0    = ferr_cnt;
    und0     = und_cnt;
    got_miso = '0;

    bus.cs = 1'b0;
    tick(HALF);
    checkOutput({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_tx_ready_start"}, 32'(bus.tx_ready), 32'd1);

    for (int i = 0; i < nbits; i++) begin
      if (mid_load && i == 5) loadTx(mid_word);
      b = 1'b0;
      if (i < W) b = word[i];
      sendBit(b, m);
      if (i < W) got_miso[i] = m;
    end
    tick(HALF);
    bus.cs = 1'b1;
    tick(HALF);

    mask     = (nbits >= W) ? '1 : W'((1 << nbits) - 1);
    exp_ferr = (nbits < W) ? 1 : nbits - W;
    if (nbits >= W) model_rx = word;

    checkOutput({tag, "_miso_bits"}, 32'(got_miso & mask), 32'(exp_tx & mask));
    checkOutput({tag, "_rx_valid_count"}, 32'(rxv_cnt - rxv0), 32'(nbits >= W));
    checkOutput({tag, "_frame_err_count"}, 32'(ferr_cnt - ferr0), 32'(exp_ferr));
    checkOutput({tag, "_underrun_count"}, 32'(und_cnt - und0), 32'(exp_und));
    checkOutput({tag, "_rx_data"}, 32'(bus.rx_data), 32'(model_rx));
    if (nbits >= W) checkOutput({tag, "_rx_at_strobe"}, 32'(last_rx), 32'(word));
    checkOutput({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_miso_idle"}, 32'(bus.miso), 32'd0);
  endtask

  initial begin
    logic [W-1:0] word5, tw, mw;
    logic         m;
    int           rxv0, ferr0, und0, nb, sel;

    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rst          = 1'b1;
    tick(4);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_miso", 32'(bus.miso), 32'd0);
    checkOutput("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("rst_underrun", 32'(bus.tx_underrun), 32'd0);
    checkOutput("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    tick(8);

    $display("[TB] loaded response frame");
    loadTx(12'hA5C);
    applyStimulus("s1", 12'h3F1, W, 1'b0, '0);

    $display("[TB] underrun frame");
    applyStimulus("s2", 12'h001, W, 1'b0, '0);

    $display("[TB] short frame then recovery");
    applyStimulus("s3", 12'h7FF, 5, 1'b0, '0);
    applyStimulus("s3b", 12'h800, W, 1'b0, '0);

    $display("[TB] back-to-back frames with mid-frame load");
    loadTx(12'h111);
    applyStimulus("s4a", 12'hABC, W, 1'b1, 12'h222);
    applyStimulus("s4b", 12'h456, W, 1'b0, '0);

    $display("[TB] reset in the middle of a frame");
    word5  = 12'h6B9;
    bus.cs = 1'b0;
    tick(HALF);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) loadTx(12'h3C3);
      sendBit(word5[i], m);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hold_q.delete();
    model_rx = '0;
    checkOutput("s5_busy", 32'(bus.busy), 32'd0);
    checkOutput("s5_miso", 32'(bus.miso), 32'd0);
    checkOutput("s5_tx_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("s5_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("s5_rx_valid", 32'(bus.rx_valid), 32'd0);
    rxv0  = rxv_cnt;
    ferr0 = ferr_cnt;
    und0  = und_cnt;
    for (int i = 6; i < W; i++) begin
      sendBit(word5[i], m);
    end
    tick(HALF);
    checkOutput("s5_no_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);
    checkOutput("s5_no_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    checkOutput("s5_no_underrun", 32'(und_cnt - und0), 32'd0);
    checkOutput("s5_idle_busy", 32'(bus.busy), 32'd0);
    bus.cs = 1'b1;
    tick(HALF);
    applyStimulus("s5b", 12'h5A5, W, 1'b0, '0);

    $display("[TB] excess sclk edge");
    applyStimulus("s6", 12'h0F0, W + 1, 1'b0, '0);

    $display("[TB] random frames");
    for (int k = 0; k < 8; k++) begin
      tw  = W'($urandom);
      mw  = W'($urandom);
      sel = int'($urandom_range(0, 5));
      if (sel < 3) nb = W;
      else if (sel == 3) nb = int'($urandom_range(1, W - 1));
      else nb = W + sel - 3;
      if ($urandom_range(0, 1) == 1) loadTx(tw);
      applyStimulus("rnd", mw, nb, 1'b0, '0);
      tick(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
